game_flow_ctrl: RTL and testbench

Central game sequencer replacing the inline top-level state FSM. It takes one-cycle event pulses from the start screen, the script, the player and the failure screen. It drives the global state code consumed by the compositor, script and player. It adds a pre-stage countdown, a stage-clear hold and automatic difficulty advance. A single registered state code is the only authority for which screen and which script run is active.

---
 rtl/game_flow_ctrl.sv | 160 ++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Central game sequencer: owns the global state code, stage countdown/clear timing and level advance.
// Optional pause support is compiled in when GAME_PAUSE_EN is defined.
//
// state       | meaning
// ------------+-------------------------------------------------
// GAMESTART 0 | start screen, waiting for a valid level choice
// EASY..INF 1-4 | stage running, script active
// FAILURE   5 | failure screen, waiting for return key
// COUNTDOWN 6 | pre-stage hold, enemies frozen
// CLEAR     7 | post-stage hold, enemies frozen
// PAUSE     8 | play suspended (GAME_PAUSE_EN builds only)
module game_flow_ctrl #(
  parameter logic [31:0] COUNTDOWN_CYC = 32'd50_000_000,
  parameter logic [31:0] CLEAR_CYC     = 32'd100_000_000,
  parameter logic [2:0]  MAX_LEVEL     = 3'd4,
  parameter logic        AUTO_ADVANCE  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_valid,
  input  logic [2:0] level_sel,
  input  logic       gameend,
  input  logic       fail,
  input  logic       ret,
  input  logic       pause_key,
  output logic [3:0] state,
  output logic [2:0] cur_level,
  output logic       script_start,
  output logic       script_run,
  output logic       freeze,
  output logic [3:0] clears
);

  typedef enum logic [3:0] {
    S_GAMESTART = 4'd0,
    S_EASY      = 4'd1,
    S_NORMAL    = 4'd2,
    S_HARD      = 4'd3,
    S_INFERNO   = 4'd4,
    S_FAILURE   = 4'd5,
    S_COUNTDOWN = 4'd6,
    S_CLEAR     = 4'd7,
    S_PAUSE     = 4'd8
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cur_level;
  logic        r_script_start;
  logic        r_script_run;
  logic        r_freeze;
  logic [3:0]  r_clears;
  logic [31:0] r_cnt;

  logic w_lvl_ok;
  assign w_lvl_ok = (level_sel != 3'd0) && (level_sel <= MAX_LEVEL);

`ifndef GAME_PAUSE_EN
  logic w_unused_pause;
  assign w_unused_pause = pause_key;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= S_GAMESTART;
      r_cur_level    <= 3'd0;
      r_script_start <= 1'b0;
      r_script_run   <= 1'b0;
      r_freeze       <= 1'b0;
      r_clears       <= 4'd0;
      r_cnt          <= 32'd0;
    end else begin
      r_script_start <= 1'b0;
      case (r_state)
        S_GAMESTART: begin
          if (level_valid && w_lvl_ok) begin
            r_state     <= S_COUNTDOWN;
            r_cur_level <= level_sel;
            r_clears    <= 4'd0;
            r_freeze    <= 1'b1;
            r_cnt       <= COUNTDOWN_CYC - 32'd1;
          end
        end
        S_COUNTDOWN: begin
          if (r_cnt == 32'd0) begin
            // play state code equals the level code, so cur_level doubles as the resume target
            r_state        <= state_t'({1'b0, r_cur_level});
            r_script_start <= 1'b1;
            r_script_run   <= 1'b1;
            r_freeze       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_EASY, S_NORMAL, S_HARD, S_INFERNO: begin
          if (fail) begin
            r_state      <= S_FAILURE;
            r_script_run <= 1'b0;
          end else if (gameend) begin
            r_state      <= S_CLEAR;
            r_script_run <= 1'b0;
            r_freeze     <= 1'b1;
            r_cnt        <= CLEAR_CYC - 32'd1;
            if (r_clears != 4'hF) r_clears <= r_clears + 4'd1;
          end
`ifdef GAME_PAUSE_EN
          else if (pause_key) begin
            r_state      <= S_PAUSE;
            r_script_run <= 1'b0;
            r_freeze     <= 1'b1;
          end
`endif
        end
        S_CLEAR: begin
          if (r_cnt == 32'd0) begin
            if (AUTO_ADVANCE && (r_cur_level < MAX_LEVEL)) begin
              r_state     <= S_COUNTDOWN;
              r_cur_level <= r_cur_level + 3'd1;
              r_cnt       <= COUNTDOWN_CYC - 32'd1;
            end else begin
              r_state     <= S_GAMESTART;
              r_cur_level <= 3'd0;
              r_freeze    <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_FAILURE: begin
          if (ret) begin
            r_state     <= S_GAMESTART;
            r_cur_level <= 3'd0;
          end
        end
`ifdef GAME_PAUSE_EN
        S_PAUSE: begin
          if (pause_key) begin
            r_state      <= state_t'({1'b0, r_cur_level});
            r_script_run <= 1'b1;
            r_freeze     <= 1'b0;
          end
        end
`endif
        default: begin
          r_state      <= S_GAMESTART;
          r_cur_level  <= 3'd0;
          r_script_run <= 1'b0;
          r_freeze     <= 1'b0;
        end
      endcase
    end
  end

  assign state        = r_state;
  assign cur_level    = r_cur_level;
  assign script_start = r_script_start;
  assign script_run   = r_script_run;
  assign freeze       = r_freeze;
  assign clears       = r_clears;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short countdown/clear timers.
// Pause scenarios are exercised when GAME_PAUSE_EN is defined.
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       level_valid;
  logic [2:0] level_sel;
  logic       gameend;
  logic       fail;
  logic       ret;
  logic       pause_key;
  logic [3:0] state;
  logic [2:0] cur_level;
  logic       script_start;
  logic       script_run;
  logic       freeze;
  logic [3:0] clears;

  int n_chk  = 0;
  int n_pass = 0;

  game_flow_ctrl #(
    .COUNTDOWN_CYC(32'd4),
    .CLEAR_CYC    (32'd3),
    .MAX_LEVEL    (3'd4),
    .AUTO_ADVANCE (1'b1)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .level_valid (level_valid),
    .level_sel   (level_sel),
    .gameend     (gameend),
    .fail        (fail),
    .ret         (ret),
    .pause_key   (pause_key),
    .state       (state),
    .cur_level   (cur_level),
    .script_start(script_start),
    .script_run  (script_run),
    .freeze      (freeze),
    .clears      (clears)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    level_valid = 1'b0;
    gameend     = 1'b0;
    fail        = 1'b0;
    ret         = 1'b0;
    pause_key   = 1'b0;
  endtask

  task automatic select(input logic [2:0] lvl);
    level_sel   = lvl;
    level_valid = 1'b1;
    tick();
    level_valid = 1'b0;
  endtask

  // checks the remaining 3 countdown cycles then the first play cycle
  task automatic finish_countdown(input string tag, input int lvl);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_cd_hold"}, state, 6);
    end
    tick();
    chk({tag, "_play_state"}, state, lvl);
    chk({tag, "_start_pulse"}, script_start, 1);
    chk({tag, "_run"}, script_run, 1);
    chk({tag, "_freeze_off"}, freeze, 0);
    tick();
    chk({tag, "_start_drop"}, script_start, 0);
  endtask

  initial begin
    rst = 1'b0;
    level_sel = 3'd0;
    clr_inputs();
    tick();
    tick();
    chk("rst_state", state, 0);
    chk("rst_level", cur_level, 0);
    chk("rst_outs", {script_start, script_run, freeze}, 0);
    chk("rst_clears", clears, 0);
    rst = 1'b1;
    tick();

    // level 2 start: 4 countdown cycles then NORMAL
    select(3'd2);
    chk("t1_cd", state, 6);
    chk("t1_cd_level", cur_level, 2);
    chk("t1_cd_freeze", freeze, 1);
    chk("t1_cd_run", script_run, 0);
    finish_countdown("t1", 2);

`ifdef GAME_PAUSE_EN
    pause_key = 1'b1; tick(); pause_key = 1'b0;
    chk("t6_pause_state", state, 8);
    chk("t6_pause_freeze", freeze, 1);
    chk("t6_pause_run", script_run, 0);
    fail = 1'b1; tick(); fail = 1'b0;
    chk("t6_fail_ignored", state, 8);
    gameend = 1'b1; tick(); gameend = 1'b0;
    chk("t6_end_ignored", state, 8);
    chk("t6_end_clears", clears, 0);
    pause_key = 1'b1; tick(); pause_key = 1'b0;
    chk("t6_resume_state", state, 2);
    chk("t6_resume_nostart", script_start, 0);
    chk("t6_resume_run", script_run, 1);
    chk("t6_resume_freeze", freeze, 0);
`else
    pause_key = 1'b1; tick(); pause_key = 1'b0;
    chk("nopause_state", state, 2);
    chk("nopause_run", script_run, 1);
`endif

    // NORMAL -> FAILURE -> GAMESTART
    fail = 1'b1; tick(); fail = 1'b0;
    chk("fail_state", state, 5);
    chk("fail_run", script_run, 0);
    ret = 1'b1; tick(); ret = 1'b0;
    chk("ret_state", state, 0);
    chk("ret_level", cur_level, 0);

    // EASY start with fail/gameend/ret pulses ignored during countdown
    select(3'd1);
    chk("t4_cd", state, 6);
    fail = 1'b1; tick(); fail = 1'b0;
    chk("t4_fail_ignored", state, 6);
    gameend = 1'b1; ret = 1'b1; tick(); gameend = 1'b0; ret = 1'b0;
    chk("t4_end_ignored", state, 6);
    chk("t4_clears", clears, 0);
    tick();
    chk("t4_cd_last", state, 6);
    tick();
    chk("t4_play", state, 1);
    chk("t4_start_pulse", script_start, 1);

    // EASY clear: 3 CLEAR cycles then auto advance to level 2
    gameend = 1'b1; tick(); gameend = 1'b0;
    chk("t2_clear", state, 7);
    chk("t2_clears", clears, 1);
    chk("t2_clear_freeze", freeze, 1);
    chk("t2_clear_run", script_run, 0);
    tick(); chk("t2_clear_hold1", state, 7);
    tick(); chk("t2_clear_hold2", state, 7);
    tick();
    chk("t2_adv_state", state, 6);
    chk("t2_adv_level", cur_level, 2);
    chk("t2_adv_freeze", freeze, 1);
    finish_countdown("t2n", 2);

    // NORMAL clear -> HARD
    gameend = 1'b1; tick(); gameend = 1'b0;
    chk("t2b_clears", clears, 2);
    tick(); tick(); tick();
    chk("t2b_adv_level", cur_level, 3);
    chk("t2b_adv_state", state, 6);
    finish_countdown("t2h", 3);

    // HARD: simultaneous fail and gameend -> fail wins
    fail = 1'b1; gameend = 1'b1; tick(); fail = 1'b0; gameend = 1'b0;
    chk("t3_state", state, 5);
    chk("t3_clears", clears, 2);
    tick();
    chk("t3_hold", state, 5);
    ret = 1'b1; tick(); ret = 1'b0;
    chk("t3_ret_state", state, 0);
    chk("t3_ret_level", cur_level, 0);
    chk("t3_clears_kept", clears, 2);

    // invalid selections ignored
    select(3'd0);
    chk("t4_sel0_state", state, 0);
    chk("t4_sel0_level", cur_level, 0);
    select(3'd5);
    chk("t4_sel5_state", state, 0);
    chk("t4_sel5_level", cur_level, 0);
    select(3'd7);
    chk("t4_sel7_state", state, 0);
    chk("t4_sel_clears", clears, 2);

    // INFERNO clear returns to GAMESTART
    select(3'd4);
    chk("t2i_clears_reset", clears, 0);
    finish_countdown("t2i", 4);
    gameend = 1'b1; tick(); gameend = 1'b0;
    chk("t2i_clear", state, 7);
    chk("t2i_clears", clears, 1);
    tick(); tick(); tick();
    chk("t2i_end_state", state, 0);
    chk("t2i_end_level", cur_level, 0);
    chk("t2i_end_freeze", freeze, 0);

    // synchronous reset mid-countdown
    select(3'd3);
    tick();
    chk("t5_cd", state, 6);
    rst = 1'b0;
    #2;
    chk("t5_no_edge_state", state, 6);
    chk("t5_no_edge_level", cur_level, 3);
    level_valid = 1'b1; level_sel = 3'd1;
    tick();
    level_valid = 1'b0;
    chk("t5_rst_state", state, 0);
    chk("t5_rst_level", cur_level, 0);
    chk("t5_rst_outs", {script_start, script_run, freeze}, 0);
    chk("t5_rst_clears", clears, 0);
    rst = 1'b1;
    tick();
    chk("t5_post_state", state, 0);
    select(3'd3);
    chk("t5_restart_cd", state, 6);
    finish_countdown("t5", 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
